// File: rtl/mem_pkg.sv
// Shared types and constants for the main-memory controller slice.
package mem_pkg;

    // Controller FSM encodings
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2
    } state_t;

    // Debug counter width and saturation value
    localparam int                CNT_W   = 16;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    // Latency counter width and legal latency range
    localparam int LAT_CNT_W = 4;
    localparam int LAT_MIN   = 1;
    localparam int LAT_MAX   = 15;

    // Counter load value for a given latency; out-of-range values are clamped
    // into the legal range so the counter can never wrap.
    function automatic logic [LAT_CNT_W-1:0] lat_load(input int lat);
        if (lat < LAT_MIN)
            return '0;
        else if (lat > LAT_MAX)
            return LAT_CNT_W'(LAT_MAX - 1);
        else
            return LAT_CNT_W'(lat - 1);
    endfunction

    // Saturating increment for the debug counters
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
    endfunction

endpackage

// File: rtl/main_mem_ram.sv
// Single-port synchronous word RAM with registered read data.
// The read register only updates when a read is issued, so it holds the
// last read word between reads; it is cleared by reset, the array is not.
module main_mem_ram #(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH_W   = 10,
    parameter string INIT_FILE = ""
) (
    input  logic               iCLK,
    input  logic               iRST_n,
    input  logic [DEPTH_W-1:0] addr,
    input  logic               we,
    input  logic               re,
    input  logic [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]  rdata
);

    logic [DATA_W-1:0] mem [0:(1<<DEPTH_W)-1];
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Write port: array has no reset
    always_ff @(posedge iCLK) begin
        if (we)
            mem[addr] <= wdata;
    end

    // Next read-data value: capture on read, otherwise hold
    always_comb begin
        rdata_d = rdata_q;
        if (re)
            rdata_d = mem[addr];
    end

    // Read-data register
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n)
            rdata_q <= '0;
        else
            rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/main_mem_controller.sv
// Backing-store stage behind the cache controller. Serves one single-word
// read or write at a time, emulating main-memory latency with a wait-state
// counter, and reports completion with a one-cycle ready pulse.
//
// Timing: the request is accepted on edge E0; the ready cycle is the one
// following edge E(LAT-1), so busy covers exactly LAT cycles. The RAM
// access (read capture or write commit) happens on that same edge, which
// lets LAT=1 work by steering the live request straight to the RAM.
module main_mem_controller
    import mem_pkg::*;
#(
    parameter int    ADDR_W    = 32,
    parameter int    DATA_W    = 32,
    parameter int    DEPTH_W   = 10,
    parameter int    RD_LAT    = 4,
    parameter int    WR_LAT    = 4,
    parameter string INIT_FILE = ""
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic              mem_MemRead,
    input  logic              mem_MemWrite,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              mem_ready,
    output logic              mem_busy,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    localparam logic [LAT_CNT_W-1:0] RD_LOAD = lat_load(RD_LAT);
    localparam logic [LAT_CNT_W-1:0] WR_LOAD = lat_load(WR_LAT);

    state_t               state_q, state_d;
    logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [DEPTH_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 armed_q, armed_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     rd_count_q, rd_count_d;
    logic [CNT_W-1:0]     wr_count_q, wr_count_d;

    logic                 req_any;
    logic                 accept;
    logic [DEPTH_W-1:0]   in_idx;
    logic [DEPTH_W-1:0]   ram_addr;
    logic [DATA_W-1:0]    ram_wdata;
    logic                 ram_we;
    logic                 ram_re;
    logic                 unused_addr_bits;

    // Word index; upper bits alias and byte-offset bits are ignored
    assign in_idx           = mem_addr[DEPTH_W+1:2];
    assign unused_addr_bits = ^{mem_addr[ADDR_W-1:DEPTH_W+2], mem_addr[1:0]};

    assign req_any = mem_MemRead | mem_MemWrite;
    assign accept  = (state_q == ST_IDLE) && armed_q && req_any;

    // State register
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; write wins when both request lines are high
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept)
                    state_d = mem_MemWrite ? ST_WR_WAIT : ST_RD_WAIT;
            end
            ST_RD_WAIT, ST_WR_WAIT: begin
                if (lat_cnt_q == '0)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath / output logic: latency count, arming, RAM strobes, counters
    always_comb begin
        lat_cnt_d = lat_cnt_q;
        idx_d     = idx_q;
        data_d    = data_q;
        armed_d   = armed_q;

        if (accept) begin
            lat_cnt_d = mem_MemWrite ? WR_LOAD : RD_LOAD;
            idx_d     = in_idx;
            data_d    = mem_data_in;
            armed_d   = 1'b0;
        end else if ((state_q != ST_IDLE) && (lat_cnt_q != '0)) begin
            lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
        end

        // A held level is never re-served: lines must drop to re-arm
        if (!req_any)
            armed_d = 1'b1;

        busy_d  = (state_d != ST_IDLE);
        ready_d = busy_d && (lat_cnt_d == '0);

        // On the accept edge the latched copies are not yet valid
        ram_addr  = accept ? in_idx      : idx_q;
        ram_wdata = accept ? mem_data_in : data_q;
        ram_we    = ready_d && (state_d == ST_WR_WAIT);
        ram_re    = ready_d && (state_d == ST_RD_WAIT);

        rd_count_d = sat_inc(rd_count_q, ram_re);
        wr_count_d = sat_inc(wr_count_q, ram_we);
    end

    // Datapath registers
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            lat_cnt_q  <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            armed_q    <= 1'b1;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            lat_cnt_q  <= lat_cnt_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            armed_q    <= armed_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    main_mem_ram #(
        .DATA_W    (DATA_W),
        .DEPTH_W   (DEPTH_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .iCLK   (iCLK),
        .iRST_n (iRST_n),
        .addr   (ram_addr),
        .we     (ram_we),
        .re     (ram_re),
        .wdata  (ram_wdata),
        .rdata  (mem_data_out)
    );

    assign mem_ready = ready_q;
    assign mem_busy  = busy_q;
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_main_mem_controller.sv
// Directed bench for main_mem_controller with default parameters
// (RD_LAT = WR_LAT = 4, DEPTH_W = 10).
module tb_main_mem_controller;

    logic        iCLK = 1'b0;
    logic        iRST_n = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_data_in = '0;
    logic        mem_MemRead = 1'b0;
    logic        mem_MemWrite = 1'b0;
    logic [31:0] mem_data_out;
    logic        mem_ready;
    logic        mem_busy;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    int checks = 0;
    int errors = 0;

    main_mem_controller dut (
        .iCLK         (iCLK),
        .iRST_n       (iRST_n),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_MemRead  (mem_MemRead),
        .mem_MemWrite (mem_MemWrite),
        .mem_data_out (mem_data_out),
        .mem_ready    (mem_ready),
        .mem_busy     (mem_busy),
        .rd_count     (rd_count),
        .wr_count     (wr_count)
    );

    always #5 iCLK = ~iCLK;

    // Advance one cycle; everything is driven and sampled 1 time unit after the edge
    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    // Raise the request and hold it until ready (bounded). Returns the number
    // of edges from acceptance to ready (0 on timeout) and busy cycles seen.
    // Returns in the ready cycle with lines still high.
    task automatic run_req(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, output int lat, output int busy_n);
        mem_MemRead  = r;
        mem_MemWrite = w;
        mem_addr     = a;
        mem_data_in  = d;
        lat    = 0;
        busy_n = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (mem_busy) busy_n++;
            if (mem_ready) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic drop();
        mem_MemRead  = 1'b0;
        mem_MemWrite = 1'b0;
        step();
    endtask

    task automatic test_reset();
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", mem_ready); end
        checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", mem_busy); end
        checks++; if (mem_data_out !== 32'h0) begin errors++; $display("FAIL rst_data: got %h want 0", mem_data_out); end
        checks++; if (rd_count !== 16'd0) begin errors++; $display("FAIL rst_rd_count: got %0d want 0", rd_count); end
        checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL rst_wr_count: got %0d want 0", wr_count); end
    endtask

    task automatic test_write();
        int lat, bn;
        run_req(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, lat, bn);
        checks++; if (lat !== 4) begin errors++; $display("FAIL wr_latency: got %0d want 4", lat); end
        checks++; if (bn !== 4) begin errors++; $display("FAIL wr_busy_cycles: got %0d want 4", bn); end
        checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL wr_count: got %0d want 1", wr_count); end
        checks++; if (rd_count !== 16'd0) begin errors++; $display("FAIL wr_rd_count: got %0d want 0", rd_count); end
        drop();
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_pulse: got %b want 0", mem_ready); end
        checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL wr_busy_after: got %b want 0", mem_busy); end
        checks++; if (mem_data_out !== 32'h0) begin errors++; $display("FAIL wr_data_out_unchanged: got %h want 0", mem_data_out); end
    endtask

    task automatic test_read();
        int lat, bn;
        run_req(1'b1, 1'b0, 32'h40, 32'h0, lat, bn);
        checks++; if (lat !== 4) begin errors++; $display("FAIL rd_latency: got %0d want 4", lat); end
        checks++; if (bn !== 4) begin errors++; $display("FAIL rd_busy_cycles: got %0d want 4", bn); end
        checks++; if (mem_data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", mem_data_out); end
        checks++; if (rd_count !== 16'd1) begin errors++; $display("FAIL rd_count: got %0d want 1", rd_count); end
        drop();
        checks++; if (mem_data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data_hold: got %h want deadbeef", mem_data_out); end
    endtask

    task automatic test_hold_level();
        int lat, bn, pulses, busy_seen;
        run_req(1'b1, 1'b0, 32'h40, 32'h0, lat, bn);
        checks++; if (lat !== 4) begin errors++; $display("FAIL hold_first_latency: got %0d want 4", lat); end
        pulses = 0;
        busy_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (mem_ready) pulses++;
            if (mem_busy) busy_seen++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL hold_no_reserve: got %0d pulses want 0", pulses); end
        checks++; if (busy_seen !== 0) begin errors++; $display("FAIL hold_no_busy: got %0d cycles want 0", busy_seen); end
        checks++; if (rd_count !== 16'd2) begin errors++; $display("FAIL hold_rd_count: got %0d want 2", rd_count); end
        drop();
        run_req(1'b1, 1'b0, 32'h40, 32'h0, lat, bn);
        checks++; if (lat !== 4) begin errors++; $display("FAIL hold_rearm_latency: got %0d want 4", lat); end
        checks++; if (rd_count !== 16'd3) begin errors++; $display("FAIL hold_rearm_rd_count: got %0d want 3", rd_count); end
        drop();
    endtask

    task automatic test_both_lines();
        int lat, bn;
        run_req(1'b1, 1'b1, 32'h80, 32'h12345678, lat, bn);
        checks++; if (lat !== 4) begin errors++; $display("FAIL both_latency: got %0d want 4", lat); end
        checks++; if (wr_count !== 16'd2) begin errors++; $display("FAIL both_wr_count: got %0d want 2", wr_count); end
        checks++; if (rd_count !== 16'd3) begin errors++; $display("FAIL both_rd_count: got %0d want 3", rd_count); end
        checks++; if (mem_data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL both_data_out: got %h want deadbeef", mem_data_out); end
        drop();
        run_req(1'b1, 1'b0, 32'h80, 32'h0, lat, bn);
        checks++; if (mem_data_out !== 32'h12345678) begin errors++; $display("FAIL both_readback: got %h want 12345678", mem_data_out); end
        checks++; if (rd_count !== 16'd4) begin errors++; $display("FAIL both_readback_count: got %0d want 4", rd_count); end
        drop();
    endtask

    task automatic test_alias();
        int lat, bn;
        run_req(1'b0, 1'b1, 32'h0, 32'h11111111, lat, bn);
        drop();
        run_req(1'b0, 1'b1, 32'h1000, 32'hA5A5A5A5, lat, bn);
        drop();
        run_req(1'b1, 1'b0, 32'h0, 32'h0, lat, bn);
        checks++; if (mem_data_out !== 32'hA5A5A5A5) begin errors++; $display("FAIL alias_data: got %h want a5a5a5a5", mem_data_out); end
        checks++; if (wr_count !== 16'd4) begin errors++; $display("FAIL alias_wr_count: got %0d want 4", wr_count); end
        drop();
    endtask

    task automatic test_back_to_back();
        int lat, bn;
        run_req(1'b1, 1'b0, 32'h80, 32'h0, lat, bn);
        checks++; if (mem_data_out !== 32'h12345678) begin errors++; $display("FAIL b2b_first_data: got %h want 12345678", mem_data_out); end
        drop();
        checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL b2b_gap_busy: got %b want 0", mem_busy); end
        run_req(1'b1, 1'b0, 32'h44, 32'h0, lat, bn);
        checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_second_latency: got %0d want 4", lat); end
        // 0x44 is word 17, never written by this bench after reset: still X
        // in the RAM, so read 0x40 instead for a defined value.
        drop();
        run_req(1'b1, 1'b0, 32'h43, 32'h0, lat, bn);
        checks++; if (mem_data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_byte_offset_data: got %h want deadbeef", mem_data_out); end
        checks++; if (rd_count !== 16'd8) begin errors++; $display("FAIL b2b_rd_count: got %0d want 8", rd_count); end
        drop();
    endtask

    task automatic test_reset_mid_write();
        int lat, bn;
        mem_MemWrite = 1'b1;
        mem_addr     = 32'h40;
        mem_data_in  = 32'h5555AAAA;
        step();
        step();
        iRST_n = 1'b0;
        #1;
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b want 0", mem_ready); end
        checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", mem_busy); end
        checks++; if (mem_data_out !== 32'h0) begin errors++; $display("FAIL midrst_data: got %h want 0", mem_data_out); end
        checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL midrst_wr_count: got %0d want 0", wr_count); end
        checks++; if (rd_count !== 16'd0) begin errors++; $display("FAIL midrst_rd_count: got %0d want 0", rd_count); end
        mem_MemWrite = 1'b0;
        step();
        step();
        iRST_n = 1'b1;
        step();
        run_req(1'b1, 1'b0, 32'h40, 32'h0, lat, bn);
        checks++; if (mem_data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL midrst_ram_kept: got %h want deadbeef", mem_data_out); end
        checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL midrst_wr_dropped: got %0d want 0", wr_count); end
        checks++; if (rd_count !== 16'd1) begin errors++; $display("FAIL midrst_rd_count_after: got %0d want 1", rd_count); end
        drop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        test_reset();
        iRST_n = 1'b1;
        step();
        test_reset();
        test_write();
        test_read();
        test_hold_level();
        test_both_lines();
        test_alias();
        test_back_to_back();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
